// File: rtl/nco_freq_meter.sv
// Recovers an NCO phase increment from a sin/cos stream: vectoring CORDIC per sample,
// modular phase differences averaged over 2^AVG_LOG2. Define NCO_FREQ_PHASE_OUT_EN for phase_o/phase_valid.
module nco_freq_meter #(
  parameter int DW       = 13,
  parameter int PW       = 32,
  parameter int ITER     = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clken,
  input  logic signed [DW-1:0] sin_i,
  input  logic signed [DW-1:0] cos_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PW-1:0]        phi_est_o,
  output logic                 out_valid,
  output logic                 zero_err
`ifdef NCO_FREQ_PHASE_OUT_EN
  ,
  output logic [PW-1:0]        phase_o,
  output logic                 phase_valid
`endif
);

  localparam int XW   = DW + 2;
  localparam int AW   = PW + AVG_LOG2;
  localparam int IW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int TW   = 1 << IW;
  localparam int CW   = AVG_LOG2 + 1;
  localparam int NAVG = 1 << AVG_LOG2;

  typedef enum logic [1:0] {IDLE, PRE, ROT, DIFF} state_t;

  // atan(2^-i) expressed in turns scaled to 2^32; rescaled below to PW bits.
  function automatic logic [63:0] atan_turn32(input int idx);
    case (idx)
      0:  atan_turn32 = 64'h2000_0000;
      1:  atan_turn32 = 64'h12E4_051E;
      2:  atan_turn32 = 64'h09FB_385B;
      3:  atan_turn32 = 64'h0511_11D4;
      4:  atan_turn32 = 64'h028B_0D43;
      5:  atan_turn32 = 64'h0145_D7E1;
      6:  atan_turn32 = 64'h00A2_F61E;
      7:  atan_turn32 = 64'h0051_7C55;
      8:  atan_turn32 = 64'h0028_BE53;
      9:  atan_turn32 = 64'h0014_5F2F;
      10: atan_turn32 = 64'h000A_2F98;
      11: atan_turn32 = 64'h0005_17CC;
      12: atan_turn32 = 64'h0002_8BE6;
      13: atan_turn32 = 64'h0001_45F3;
      14: atan_turn32 = 64'h0000_A2FA;
      15: atan_turn32 = 64'h0000_517D;
      16: atan_turn32 = 64'h0000_28BE;
      17: atan_turn32 = 64'h0000_145F;
      18: atan_turn32 = 64'h0000_0A30;
      19: atan_turn32 = 64'h0000_0518;
      20: atan_turn32 = 64'h0000_028C;
      21: atan_turn32 = 64'h0000_0146;
      22: atan_turn32 = 64'h0000_00A3;
      23: atan_turn32 = 64'h0000_0051;
      24: atan_turn32 = 64'h0000_0029;
      25: atan_turn32 = 64'h0000_0014;
      26: atan_turn32 = 64'h0000_000A;
      27: atan_turn32 = 64'h0000_0005;
      28: atan_turn32 = 64'h0000_0003;
      29: atan_turn32 = 64'h0000_0001;
      default: atan_turn32 = 64'd0;
    endcase
  endfunction

  function automatic logic [PW-1:0] atan_entry(input int idx);
    logic [63:0] v;
    int sh;
    v  = atan_turn32(idx);
    sh = (PW >= 32) ? (PW - 32) : (32 - PW);
    if (PW >= 32) v = v << sh;
    else          v = (v + (64'd1 << (sh - 1))) >> sh;
    return v[PW-1:0];
  endfunction

  logic [PW-1:0] atan_tab [TW];
  generate
    for (genvar gi = 0; gi < TW; gi++) begin : g_atan
      assign atan_tab[gi] = atan_entry(gi);
    end
  endgenerate

  state_t                state_reg, state_next;
  logic signed [XW-1:0]  x_reg, x_next, y_reg, y_next;
  logic [PW-1:0]         z_reg, z_next, prev_reg, prev_next, est_reg, est_next;
  logic [IW-1:0]         i_reg, i_next;
  logic [AW-1:0]         acc_reg, acc_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  have_prev_reg, have_prev_next;
  logic                  ov_reg, ov_next, zero_reg, zero_next;
`ifdef NCO_FREQ_PHASE_OUT_EN
  logic [PW-1:0]         phase_reg, phase_next;
  logic                  pv_reg, pv_next;
`endif

  logic signed [XW-1:0]  x_sh, y_sh;
  logic [PW-1:0]         d;
  logic [AW-1:0]         acc_sum;

  assign x_sh    = x_reg >>> i_reg;
  assign y_sh    = y_reg >>> i_reg;
  assign d       = z_reg - prev_reg;
  assign acc_sum = acc_reg + {{AVG_LOG2{d[PW-1]}}, d};

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    z_next         = z_reg;
    i_next         = i_reg;
    prev_next      = prev_reg;
    est_next       = est_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    have_prev_next = have_prev_reg;
    zero_next      = zero_reg;
    ov_next        = 1'b0;
`ifdef NCO_FREQ_PHASE_OUT_EN
    phase_next     = phase_reg;
    pv_next        = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          x_next = {{2{cos_i[DW-1]}}, cos_i};
          y_next = {{2{sin_i[DW-1]}}, sin_i};
          if (cos_i == '0 && sin_i == '0) zero_next = 1'b1;
          else                            state_next = PRE;
        end
      end
      PRE: begin
        // Fold the left half-plane onto the right so CORDIC stays within its range.
        if (x_reg[XW-1]) begin
          x_next = -x_reg;
          y_next = -y_reg;
          z_next = {1'b1, {(PW-1){1'b0}}};
        end else begin
          z_next = '0;
        end
        i_next     = '0;
        state_next = ROT;
      end
      ROT: begin
        if (!y_reg[XW-1]) begin
          x_next = x_reg + y_sh;
          y_next = y_reg - x_sh;
          z_next = z_reg + atan_tab[i_reg];
        end else begin
          x_next = x_reg - y_sh;
          y_next = y_reg + x_sh;
          z_next = z_reg - atan_tab[i_reg];
        end
        if (i_reg == IW'(ITER - 1)) state_next = DIFF;
        else                        i_next     = i_reg + 1'b1;
      end
      DIFF: begin
`ifdef NCO_FREQ_PHASE_OUT_EN
        phase_next = z_reg;
        pv_next    = 1'b1;
`endif
        prev_next = z_reg;
        if (!have_prev_reg) begin
          have_prev_next = 1'b1;
        end else if (cnt_reg == CW'(NAVG - 1)) begin
          est_next = acc_sum[AW-1:AVG_LOG2];
          ov_next  = 1'b1;
          acc_next = '0;
          cnt_next = '0;
        end else begin
          acc_next = acc_sum;
          cnt_next = cnt_reg + 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      i_reg         <= '0;
      prev_reg      <= '0;
      est_reg       <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      have_prev_reg <= 1'b0;
      ov_reg        <= 1'b0;
      zero_reg      <= 1'b0;
`ifdef NCO_FREQ_PHASE_OUT_EN
      phase_reg     <= '0;
      pv_reg        <= 1'b0;
`endif
    end else if (clken) begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      z_reg         <= z_next;
      i_reg         <= i_next;
      prev_reg      <= prev_next;
      est_reg       <= est_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      have_prev_reg <= have_prev_next;
      ov_reg        <= ov_next;
      zero_reg      <= zero_next;
`ifdef NCO_FREQ_PHASE_OUT_EN
      phase_reg     <= phase_next;
      pv_reg        <= pv_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign phi_est_o = est_reg;
  assign out_valid = ov_reg & clken;
  assign zero_err  = zero_reg;
`ifdef NCO_FREQ_PHASE_OUT_EN
  assign phase_o     = phase_reg;
  assign phase_valid = pv_reg & clken;
`endif

endmodule
